// File: rtl/pov_spi_tx_pkg.sv
// pov_spi_tx shared constants: fixed-point vector width, frame layout, FSM states.
// The raycaster SPI receiver is built from the same values.
package pov_spi_tx_pkg;

  localparam int POV_WORD_W  = 16;
  localparam int POV_NWORDS  = 6;
  localparam int POV_CLK_DIV = 2;
  localparam int POV_FRAME_W = POV_WORD_W * POV_NWORDS;

  // Wire order of the vectors; index 0 goes out first.
  typedef enum logic [2:0] {
    VEC_PLAYER_X,
    VEC_PLAYER_Y,
    VEC_FACING_X,
    VEC_FACING_Y,
    VEC_VPLANE_X,
    VEC_VPLANE_Y
  } vec_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_t;

  // MSB position of a vector inside the packed frame.
  function automatic int frame_msb(vec_e v);
    return POV_FRAME_W - 1 - int'(v) * POV_WORD_W;
  endfunction

endpackage

// File: rtl/pov_spi_tx_if.sv
// pov_spi_tx request/SPI bundle.
// master drives the request side, slave is the transmitter.
interface pov_spi_tx_if
  import pov_spi_tx_pkg::*;
#(
  parameter int WORD_W = POV_WORD_W
);

  logic              i_start;
  logic [WORD_W-1:0] i_playerX;
  logic [WORD_W-1:0] i_playerY;
  logic [WORD_W-1:0] i_facingX;
  logic [WORD_W-1:0] i_facingY;
  logic [WORD_W-1:0] i_vplaneX;
  logic [WORD_W-1:0] i_vplaneY;
  logic              o_busy;
  logic              o_done;
  logic              o_sclk;
  logic              o_mosi;
  logic              o_ss_n;

  modport master (
    output i_start,
    output i_playerX, i_playerY,
    output i_facingX, i_facingY,
    output i_vplaneX, i_vplaneY,
    input  o_busy, o_done,
    input  o_sclk, o_mosi, o_ss_n
  );

  modport slave (
    input  i_start,
    input  i_playerX, i_playerY,
    input  i_facingX, i_facingY,
    input  i_vplaneX, i_vplaneY,
    output o_busy, o_done,
    output o_sclk, o_mosi, o_ss_n
  );

endinterface

// File: rtl/pov_spi_tx_clkgen.sv
// SCLK generator: half-period counter with rise/fall strobes.
// Strobes announce what the sclk register does on the coming edge.
module pov_spi_tx_clkgen
  import pov_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = POV_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic toggle,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

  logic [HC_W-1:0] hcnt;

  assign tick = run && (hcnt == HC_LAST);
  assign rise = tick && toggle && !sclk;
  assign fall = tick && toggle && sclk;

  // half-period counter, parked at zero while idle
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      hcnt <= '0;
    end else if (tick) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + HC_W'(1);
    end
  end

  // sclk idles low and toggles on each tick when asked
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      sclk <= 1'b0;
    end else if (tick && toggle) begin
      sclk <= !sclk;
    end
  end

endmodule

// File: rtl/pov_spi_tx.sv
// pov_spi_tx: mode-0 SPI master sending one six-vector camera set.
// Optional POV_TX_SKIP_UNCHANGED_EN suppresses frames equal to the last one sent.
module pov_spi_tx
  import pov_spi_tx_pkg::*;
#(
  parameter int WORD_W  = POV_WORD_W,
  parameter int NWORDS  = POV_NWORDS,
  parameter int CLK_DIV = POV_CLK_DIV
) (
  input logic          clk,
  input logic          reset,
  pov_spi_tx_if.slave  bus
);

  localparam int FRAME_W = WORD_W * NWORDS;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);

  state_t             state;
  state_t             state_nx;
  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] sr_nx;
  logic [BC_W-1:0]    bcnt;
  logic [BC_W-1:0]    bcnt_nx;
  logic               ss_n;
  logic               ss_n_nx;
  logic               busy;
  logic               busy_nx;
  logic               done;
  logic               done_nx;
  logic               mosi;
  logic               mosi_nx;
  logic               run;
  logic               toggle;
  logic               tick;
  logic               rise;
  logic               fall;
  logic               sclk;
  logic               skip;

  assign frame_in = {
    bus.i_playerX, bus.i_playerY,
    bus.i_facingX, bus.i_facingY,
    bus.i_vplaneX, bus.i_vplaneY
  };

  assign run    = (state != ST_IDLE);
  assign toggle = (state == ST_LEAD) ||
                  (state == ST_SHIFT);

  pov_spi_tx_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .toggle (toggle),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sclk   (sclk)
  );

`ifdef POV_TX_SKIP_UNCHANGED_EN
  logic [FRAME_W-1:0] shadow;

  assign skip = (frame_in == shadow);

  // remember the set the receiver last got in full;
  // sr has rotated back to its loaded value by then
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (state == ST_TRAIL && tick) begin
      shadow <= sr;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and next values of the registered outputs
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    bcnt_nx  = bcnt;
    ss_n_nx  = ss_n;
    busy_nx  = busy;
    done_nx  = 1'b0;
    mosi_nx  = mosi;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (skip) begin
            done_nx = 1'b1;
          end else begin
            sr_nx    = frame_in;
            bcnt_nx  = BC_LAST;
            ss_n_nx  = 1'b0;
            busy_nx  = 1'b1;
            mosi_nx  = frame_in[FRAME_W-1];
            state_nx = ST_LEAD;
          end
        end
      end
      ST_LEAD: begin
        if (rise) begin
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          sr_nx = {sr[FRAME_W-2:0], sr[FRAME_W-1]};
          if (bcnt == '0) begin
            mosi_nx  = 1'b0;
            state_nx = ST_TRAIL;
          end else begin
            mosi_nx = sr[FRAME_W-2];
            bcnt_nx = bcnt - BC_W'(1);
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          ss_n_nx  = 1'b1;
          done_nx  = 1'b1;
          state_nx = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          busy_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      bcnt <= '0;
      ss_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      mosi <= 1'b0;
    end else begin
      sr   <= sr_nx;
      bcnt <= bcnt_nx;
      ss_n <= ss_n_nx;
      busy <= busy_nx;
      done <= done_nx;
      mosi <= mosi_nx;
    end
  end

  assign bus.o_sclk = sclk;
  assign bus.o_mosi = mosi;
  assign bus.o_ss_n = ss_n;
  assign bus.o_busy = busy;
  assign bus.o_done = done;

endmodule
